// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed image over rx and writes it word by word.
// Optional checksum byte checking is enabled with `define BOOT_CKSUM_EN.
module uart_boot_loader #(
  parameter int BAUD_DIV  = 434,
  parameter int MAX_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        boot_we,
  output logic [14:0] boot_waddr,
  output logic [31:0] boot_wdata,
  output logic        boot_en,
  output logic        boot_done,
  output logic        boot_err
);

  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, WORD,
`ifdef BOOT_CKSUM_EN
    CHK,
`endif
    DONE
  } st_t;

  logic [1:0]    sync_q;
  logic          prev_q;
  logic          rx_s;
  logic          fall;
  rx_st_t        rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          rx_vld;
  logic          rx_ferr;

  st_t           st_q, st_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   n_w;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   widx_q, widx_d;
  logic [23:0]   asm_q, asm_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [14:0]   waddr_q, waddr_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
`ifdef BOOT_CKSUM_EN
  logic [7:0]    ck_q, ck_d;
`else
  logic          fin_q, fin_d;
`endif

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;
  assign n_w  = {sh_q, len_q[7:0]};

  // Two-flop synchronizer plus edge-detect history for rx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      prev_q <= rx_s;
    end
  end

  // Byte receiver state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q  <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
    end else begin
      rx_q  <= rx_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
    end
  end

  // Byte receiver: mid-bit sampling, byte strobe at stop sample.
  always_comb begin
    rx_d    = rx_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rx_vld  = 1'b0;
    rx_ferr = 1'b0;
    unique case (rx_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) rx_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          rx_d  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(BAUD_DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(BAUD_DIV - 1)) begin
          cnt_d   = '0;
          rx_d    = RX_IDLE;
          rx_vld  = rx_s;
          rx_ferr = ~rx_s;
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      widx_q  <= '0;
      asm_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef BOOT_CKSUM_EN
      ck_q    <= '0;
`else
      fin_q   <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      widx_q  <= widx_d;
      asm_q   <= asm_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef BOOT_CKSUM_EN
      ck_q    <= ck_d;
`else
      fin_q   <= fin_d;
`endif
    end
  end

  // Frame FSM: parses sync, count, words and checksum.
  always_comb begin
    st_d    = st_q;
    len_d   = len_q;
    idx_d   = idx_q;
    widx_d  = widx_q;
    asm_d   = asm_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    we_d    = 1'b0;
    err_d   = err_q;
`ifdef BOOT_CKSUM_EN
    ck_d    = ck_q;
`else
    fin_d   = fin_q;
    if (st_q == WORD && fin_q) st_d = DONE;
`endif
    if (rx_ferr && st_q != DONE) begin
      err_d = 1'b1;
      st_d  = IDLE;
    end else if (rx_vld) begin
      unique case (st_q)
        IDLE: begin
          if (sh_q == 8'hA5) begin
            st_d  = LEN0;
            err_d = 1'b0;
`ifdef BOOT_CKSUM_EN
            ck_d  = '0;
`endif
          end
        end
        LEN0: begin
          len_d[7:0] = sh_q;
          st_d       = LEN1;
        end
        LEN1: begin
          len_d  = n_w;
          idx_d  = '0;
          widx_d = '0;
`ifndef BOOT_CKSUM_EN
          fin_d  = 1'b0;
`endif
          if (32'(n_w) > MAX_WORDS) begin
            err_d = 1'b1;
            st_d  = IDLE;
          end else if (n_w == 16'd0) begin
`ifdef BOOT_CKSUM_EN
            st_d = CHK;
`else
            st_d = DONE;
`endif
          end else begin
            st_d = WORD;
          end
        end
        WORD: begin
          idx_d = idx_q + 1'b1;
`ifdef BOOT_CKSUM_EN
          ck_d  = ck_q ^ sh_q;
`endif
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {sh_q, asm_q};
            waddr_d = {widx_q[12:0], 2'b00};
            widx_d  = widx_q + 1'b1;
            if (widx_q == len_q - 1'b1) begin
`ifdef BOOT_CKSUM_EN
              st_d = CHK;
`else
              fin_d = 1'b1;
`endif
            end
          end else begin
            asm_d[{idx_q, 3'b000} +: 8] = sh_q;
          end
        end
`ifdef BOOT_CKSUM_EN
        CHK: begin
          if (sh_q == ck_q) begin
            st_d = DONE;
          end else begin
            err_d = 1'b1;
            st_d  = IDLE;
          end
        end
`endif
        DONE: st_d = DONE;
        default: st_d = IDLE;
      endcase
    end
  end

  assign boot_we    = we_q;
  assign boot_waddr = waddr_q;
  assign boot_wdata = wdata_q;
  assign boot_en    = (st_q != DONE);
  assign boot_done  = (st_q == DONE);
  assign boot_err   = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader at BAUD_DIV=16.
// Frames carry a checksum byte only when BOOT_CKSUM_EN is defined.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        boot_we;
  logic [14:0] boot_waddr;
  logic [31:0] boot_wdata;
  logic        boot_en;
  logic        boot_done;
  logic        boot_err;

  int n_cmp = 0;
  int n_bad = 0;
  int we_n = 0;
  int wide = 0;
  logic prev_we = 1'b0;
  logic [14:0] wa [0:63];
  logic [31:0] wd [0:63];

  localparam logic [7:0] GOOD [0:10] = '{
    8'hA5, 8'h02, 8'h00,
    8'h13, 8'h00, 8'h00, 8'h00,
    8'h93, 8'h00, 8'h10, 8'h00
  };

  uart_boot_loader #(
    .BAUD_DIV(16),
    .MAX_WORDS(8192)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .boot_we(boot_we),
    .boot_waddr(boot_waddr),
    .boot_wdata(boot_wdata),
    .boot_en(boot_en),
    .boot_done(boot_done),
    .boot_err(boot_err)
  );

  initial forever #5 clk = ~clk;

  // Log every write strobe and any strobe longer than a cycle.
  always @(negedge clk) begin
    prev_we <= boot_we;
    if (boot_we && prev_we) wide <= wide + 1;
    if (boot_we && we_n < 64) begin
      wa[we_n] <= boot_waddr;
      wd[we_n] <= boot_wdata;
      we_n <= we_n + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input logic stp);
    rx = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(posedge clk);
    end
    rx = stp;
    repeat (16) @(posedge clk);
    rx = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic send_frame(input int from,
                            input logic [7:0] ck);
    for (int i = from; i < 11; i++)
      send_byte(GOOD[i], 1'b1);
`ifdef BOOT_CKSUM_EN
    send_byte(ck, 1'b1);
`else
    if (ck == 8'h00) rx = 1'b1;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (boot_en !== 1'b1) begin
      n_bad++; $display("FAIL rst_en got %b want 1", boot_en);
    end
    n_cmp++;
    if (boot_we !== 1'b0) begin
      n_bad++; $display("FAIL rst_we got %b want 0", boot_we);
    end
    n_cmp++;
    if (boot_done !== 1'b0) begin
      n_bad++; $display("FAIL rst_done got %b want 0", boot_done);
    end
    n_cmp++;
    if (boot_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_err got %b want 0", boot_err);
    end
    n_cmp++;
    if (boot_waddr !== 15'h0000) begin
      n_bad++; $display("FAIL rst_waddr got %h want 0000", boot_waddr);
    end
    n_cmp++;
    if (boot_wdata !== 32'h0) begin
      n_bad++; $display("FAIL rst_wdata got %h want 00000000", boot_wdata);
    end
  endtask

  task automatic test_good();
    int base;
    do_reset();
    base = we_n;
    send_frame(0, 8'h90);
    n_cmp++;
    if (we_n - base !== 2) begin
      n_bad++; $display("FAIL good_cnt got %0d want 2", we_n - base);
    end
    n_cmp++;
    if (wa[base] !== 15'h0000 || wd[base] !== 32'h00000013) begin
      n_bad++;
      $display("FAIL good_w0 got %h/%h want 0000/00000013", wa[base], wd[base]);
    end
    n_cmp++;
    if (wa[base+1] !== 15'h0004 || wd[base+1] !== 32'h00100093) begin
      n_bad++;
      $display("FAIL good_w1 got %h/%h want 0004/00100093",
               wa[base+1], wd[base+1]);
    end
    n_cmp++;
    if ({boot_done, boot_en, boot_err} !== 3'b100) begin
      n_bad++;
      $display("FAIL good_flags got %b want 100",
               {boot_done, boot_en, boot_err});
    end
    n_cmp++;
    if (boot_wdata !== 32'h00100093 || boot_waddr !== 15'h0004) begin
      n_bad++;
      $display("FAIL good_hold got %h/%h want 0004/00100093",
               boot_waddr, boot_wdata);
    end
    n_cmp++;
    if (wide !== 0) begin
      n_bad++; $display("FAIL we_width got %0d long pulses want 0", wide);
    end
    base = we_n;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h11, 1'b1);
    n_cmp++;
    if (we_n !== base || boot_done !== 1'b1 || boot_en !== 1'b0) begin
      n_bad++;
      $display("FAIL done_term got we %0d done %b en %b want 0 1 0",
               we_n - base, boot_done, boot_en);
    end
  endtask

`ifdef BOOT_CKSUM_EN
  task automatic test_bad_cksum();
    int base;
    do_reset();
    base = we_n;
    send_frame(0, 8'h91);
    n_cmp++;
    if ({boot_err, boot_en, boot_done} !== 3'b110) begin
      n_bad++;
      $display("FAIL ck_bad got err/en/done %b want 110",
               {boot_err, boot_en, boot_done});
    end
    n_cmp++;
    if (we_n - base !== 2) begin
      n_bad++; $display("FAIL ck_bad_cnt got %0d want 2", we_n - base);
    end
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (boot_err !== 1'b0) begin
      n_bad++; $display("FAIL ck_sync_clr got %b want 0", boot_err);
    end
    base = we_n;
    send_frame(1, 8'h90);
    n_cmp++;
    if ({boot_done, boot_err} !== 2'b10 || wa[base] !== 15'h0) begin
      n_bad++;
      $display("FAIL ck_resend got done/err %b a0 %h want 10 0000",
               {boot_done, boot_err}, wa[base]);
    end
  endtask
`endif

  task automatic test_noise_framing();
    int base;
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({boot_err, boot_en, boot_done} !== 3'b010) begin
      n_bad++;
      $display("FAIL noise got err/en/done %b want 010",
               {boot_err, boot_en, boot_done});
    end
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({boot_err, boot_en} !== 2'b11) begin
      n_bad++;
      $display("FAIL frame_err got err/en %b want 11", {boot_err, boot_en});
    end
    base = we_n;
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    n_cmp++;
    if (we_n !== base || boot_done !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_idle got we %0d done %b want 0 0",
               we_n - base, boot_done);
    end
    send_frame(0, 8'h90);
    n_cmp++;
    if (boot_done !== 1'b1 || wa[base] !== 15'h0 ||
        wd[base] !== 32'h13) begin
      n_bad++;
      $display("FAIL frame_recover got done %b %h/%h want 1 0000/00000013",
               boot_done, wa[base], wd[base]);
    end
  endtask

  task automatic test_too_long();
    int base;
    do_reset();
    base = we_n;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h20, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({boot_err, boot_en, boot_done} !== 3'b110) begin
      n_bad++;
      $display("FAIL too_long got err/en/done %b want 110",
               {boot_err, boot_en, boot_done});
    end
    for (int i = 0; i < 4; i++) send_byte(8'h13, 1'b1);
    n_cmp++;
    if (we_n !== base) begin
      n_bad++; $display("FAIL too_long_we got %0d want 0", we_n - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    base = we_n;
    for (int i = 0; i < 7; i++) send_byte(GOOD[i], 1'b1);
    n_cmp++;
    if (we_n - base !== 1) begin
      n_bad++; $display("FAIL mid_first got %0d want 1", we_n - base);
    end
    do_reset();
    n_cmp++;
    if (boot_waddr !== 15'h0 || boot_en !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_rst got %h en %b want 0000 1", boot_waddr, boot_en);
    end
    base = we_n;
    send_frame(0, 8'h90);
    n_cmp++;
    if (wa[base] !== 15'h0000 || wa[base+1] !== 15'h0004) begin
      n_bad++;
      $display("FAIL mid_addr got %h %h want 0000 0004",
               wa[base], wa[base+1]);
    end
    n_cmp++;
    if (we_n - base !== 2 || boot_done !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_done got %0d %b want 2 1", we_n - base, boot_done);
    end
  endtask

  initial begin
    test_reset();
    test_good();
`ifdef BOOT_CKSUM_EN
    test_bad_cksum();
`endif
    test_noise_framing();
    test_too_long();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
